// File: rtl/enemy_fleet_ctrl.sv
// enemy_fleet_ctrl: marches an enemy formation across the screen, drops at the edges, tracks kills and wave end
//
// Ports:
//   Clk               system clock
//   Reset             asynchronous active-high reset
//   frame_clk         vsync-rate frame strobe, asynchronous to Clk
//   start             level; begins a wave when not playing
//   hit_vec           per-enemy hit pulse, bit i = enemy i
//   fleet_x, fleet_y  formation origin
//   enemy_direction_X 0 = left, 1 = right (current or next horizontal direction)
//   enemy_direction_Y 1 while descending
//   is_playing        high in MARCH_R, MARCH_L, DROP
//   delete_enemies    one-Clk pulse on entry to CLEAR or INVADED
//   alive             live-enemy mask
//   alive_count       registered popcount of alive
//   wave_clear        high while in CLEAR
//   invaded           high while in INVADED
//
// Optional feature: define ENEMY_SPEEDUP_EN to shorten the step divider as the fleet thins out.
module enemy_fleet_ctrl #(
    parameter int         NUM_ENEMIES = 8,
    parameter logic [9:0] START_X     = 10'd120,
    parameter logic [9:0] START_Y     = 10'd40,
    parameter logic [9:0] FLEET_WIDTH = 10'd400,
    parameter logic [9:0] LEFT_BOUND  = 10'd0,
    parameter logic [9:0] RIGHT_BOUND = 10'd639,
    parameter int         DROP_STEPS  = 10,
    parameter logic [9:0] FLOOR_Y     = 10'd430,
    parameter int         FRAME_DIV   = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic                   start,
    input  logic [NUM_ENEMIES-1:0] hit_vec,
    output logic [9:0]             fleet_x,
    output logic [9:0]             fleet_y,
    output logic                   enemy_direction_X,
    output logic                   enemy_direction_Y,
    output logic                   is_playing,
    output logic                   delete_enemies,
    output logic [NUM_ENEMIES-1:0] alive,
    output logic [7:0]             alive_count,
    output logic                   wave_clear,
    output logic                   invaded
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MARCH_R = 3'd1;
    localparam logic [2:0] MARCH_L = 3'd2;
    localparam logic [2:0] DROP    = 3'd3;
    localparam logic [2:0] CLEAR   = 3'd4;
    localparam logic [2:0] INVADED = 3'd5;
    localparam logic [7:0] DIV_FULL = 8'(FRAME_DIV);
    localparam logic [7:0] DIV_HALF = 8'((FRAME_DIV / 2 > 1) ? FRAME_DIV / 2 : 1);
    localparam logic [7:0] DROP_LAST = 8'(DROP_STEPS - 1);

    logic [2:0]  state;
    logic [2:0]  fsync;
    logic [7:0]  div_cnt;
    logic [7:0]  cur_div;
    logic [7:0]  div_sel;
    logic [7:0]  drop_cnt;
    logic        frame_tick;
    logic        step_tick;
    logic        start_ok;
    logic        at_right;

`ifdef ENEMY_SPEEDUP_EN
    assign div_sel = (alive_count == 8'd1) ? 8'd1 :
                     (alive_count > 8'(NUM_ENEMIES / 2)) ? DIV_FULL : DIV_HALF;
`else
    assign div_sel = DIV_FULL;
`endif

    // fsync[1:0] is the two-flop synchronizer, fsync[2] the edge register
    assign frame_tick = fsync[1] & ~fsync[2];
    // >= keeps the divider safe when cur_div shrinks below the running count
    assign step_tick  = frame_tick && (div_cnt + 8'd1 >= cur_div);
    assign start_ok   = start && !is_playing;
    assign at_right   = ({1'b0, fleet_x} + {1'b0, FLEET_WIDTH} + 11'd1) > {1'b0, RIGHT_BOUND};

    assign is_playing        = (state == MARCH_R) || (state == MARCH_L) || (state == DROP);
    assign wave_clear        = state == CLEAR;
    assign invaded           = state == INVADED;
    assign enemy_direction_Y = state == DROP;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state             <= IDLE;
            fsync             <= '0;
            div_cnt           <= '0;
            cur_div           <= DIV_FULL;
            drop_cnt          <= '0;
            fleet_x           <= START_X;
            fleet_y           <= START_Y;
            alive             <= '0;
            alive_count       <= '0;
            enemy_direction_X <= 1'b1;
            delete_enemies    <= 1'b0;
        end else begin
            fsync          <= {fsync[1:0], frame_clk};
            alive_count    <= 8'($countones(alive));
            delete_enemies <= 1'b0;
            div_cnt        <= start_ok ? 8'd0 : step_tick ? 8'd0 : frame_tick ? div_cnt + 8'd1 : div_cnt;
            cur_div        <= start_ok ? DIV_FULL : step_tick ? div_sel : cur_div;
            if (start_ok) begin
                state             <= MARCH_R;
                fleet_x           <= START_X;
                fleet_y           <= START_Y;
                alive             <= '1;
                drop_cnt          <= '0;
                enemy_direction_X <= 1'b1;
            end else if (is_playing) begin
                alive <= alive & ~hit_vec;
                if (alive == '0) begin
                    state          <= CLEAR;
                    delete_enemies <= 1'b1;
                end else if (fleet_y >= FLOOR_Y) begin
                    state          <= INVADED;
                    delete_enemies <= 1'b1;
                end else if (step_tick) begin
                    if (state == MARCH_R) begin
                        if (at_right) begin
                            state             <= DROP;
                            enemy_direction_X <= 1'b0;
                        end else begin
                            fleet_x <= fleet_x + 10'd1;
                        end
                    end else if (state == MARCH_L) begin
                        if (fleet_x <= LEFT_BOUND) begin
                            state             <= DROP;
                            enemy_direction_X <= 1'b1;
                        end else begin
                            fleet_x <= fleet_x - 10'd1;
                        end
                    end else begin
                        fleet_y  <= fleet_y + 10'd1;
                        drop_cnt <= (drop_cnt == DROP_LAST) ? 8'd0 : drop_cnt + 8'd1;
                        if (drop_cnt == DROP_LAST)
                            state <= enemy_direction_X ? MARCH_R : MARCH_L;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// tb_enemy_fleet_ctrl: directed vector bench for enemy_fleet_ctrl
module tb_enemy_fleet_ctrl;
`ifdef ENEMY_SPEEDUP_EN
    localparam bit SPD = 1'b1;
`else
    localparam bit SPD = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] hit0 = 8'h00;
    logic [7:0] hit1 = 8'h00;
    logic [9:0] x0, y0, x1, y1;
    logic       dx0, dy0, play0, del0, clr0, inv0;
    logic       dx1, dy1, play1, del1, clr1, inv1;
    logic [7:0] alive0, cnt0, alive1, cnt1;
    int         n_chk = 0;
    int         n_fail = 0;
    int         del_seen;

    always #5 Clk = ~Clk;

    enemy_fleet_ctrl u0 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start0), .hit_vec(hit0),
        .fleet_x(x0), .fleet_y(y0), .enemy_direction_X(dx0), .enemy_direction_Y(dy0),
        .is_playing(play0), .delete_enemies(del0), .alive(alive0), .alive_count(cnt0),
        .wave_clear(clr0), .invaded(inv0)
    );

    // starts at the right edge with a shallow floor so the floor corner cases are quick to reach
    enemy_fleet_ctrl #(.START_X(10'd239), .FLOOR_Y(10'd41), .FRAME_DIV(1)) u1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start1), .hit_vec(hit1),
        .fleet_x(x1), .fleet_y(y1), .enemy_direction_X(dx1), .enemy_direction_Y(dy1),
        .is_playing(play1), .delete_enemies(del1), .alive(alive1), .alive_count(cnt1),
        .wave_clear(clr1), .invaded(inv1)
    );

    typedef struct {
        logic [7:0] hit;
        int         frames;
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic [7:0] alive;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one frame_clk period; the step lands on the third Clk edge after the rise
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h00, 4,   10'd122, 10'd40, 1'b1, 1'b0, 8'hFF, 8'd8};
        vecs[1]  = '{8'h01, 0,   10'd122, 10'd40, 1'b1, 1'b0, 8'hFE, 8'd7};
        vecs[2]  = '{8'h01, 0,   10'd122, 10'd40, 1'b1, 1'b0, 8'hFE, 8'd7};
        vecs[3]  = '{8'h00, 8,   10'd124, 10'd40, 1'b1, 1'b0, 8'hFE, 8'd7};
        vecs[4]  = '{8'h00, 464, 10'd239, 10'd40, 1'b0, 1'b1, 8'hFE, 8'd7};
        vecs[5]  = '{8'h00, 36,  10'd239, 10'd49, 1'b0, 1'b1, 8'hFE, 8'd7};
        vecs[6]  = '{8'h00, 4,   10'd239, 10'd50, 1'b0, 1'b0, 8'hFE, 8'd7};
        vecs[7]  = '{8'h00, 4,   10'd238, 10'd50, 1'b0, 1'b0, 8'hFE, 8'd7};
        vecs[8]  = '{8'h02, 0,   10'd238, 10'd50, 1'b0, 1'b0, 8'hFC, 8'd6};
        vecs[9]  = '{8'h0C, 4,   10'd237, 10'd50, 1'b0, 1'b0, 8'hF0, 8'd4};
        vecs[10] = '{8'h00, 2,   SPD ? 10'd236 : 10'd237, 10'd50, 1'b0, 1'b0, 8'hF0, 8'd4};
        vecs[11] = '{8'h00, 2,   SPD ? 10'd235 : 10'd236, 10'd50, 1'b0, 1'b0, 8'hF0, 8'd4};
        vecs[12] = '{8'h70, 0,   SPD ? 10'd235 : 10'd236, 10'd50, 1'b0, 1'b0, 8'h80, 8'd1};
        vecs[13] = '{8'h00, 2,   SPD ? 10'd234 : 10'd236, 10'd50, 1'b0, 1'b0, 8'h80, 8'd1};
        vecs[14] = '{8'h00, 1,   SPD ? 10'd233 : 10'd236, 10'd50, 1'b0, 1'b0, 8'h80, 8'd1};
        vecs[15] = '{8'h00, 1,   SPD ? 10'd232 : 10'd235, 10'd50, 1'b0, 1'b0, 8'h80, 8'd1};

        repeat (3) @(negedge Clk);
        chk("rst_x", x0, 10'd120);
        chk("rst_y", y0, 10'd40);
        chk("rst_alive", alive0, 8'h00);
        chk("rst_cnt", cnt0, 8'd0);
        chk("rst_dx", dx0, 1'b1);
        chk("rst_dy", dy0, 1'b0);
        chk("rst_flags", {play0, del0, clr0, inv0}, 4'b0000);

        @(negedge Clk) Reset = 1'b0;
        @(negedge Clk) start0 = 1'b1;
        frames(4);
        start0 = 1'b0;
        chk("start_x", x0, 10'd121);
        chk("start_play", play0, 1'b1);
        chk("start_alive", alive0, 8'hFF);
        chk("start_dx", dx0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].hit != 8'h00) begin
                @(negedge Clk) hit0 = vecs[i].hit;
                @(negedge Clk) hit0 = 8'h00;
                @(negedge Clk);
            end
            frames(vecs[i].frames);
            chk($sformatf("v%0d_x", i), x0, vecs[i].x);
            chk($sformatf("v%0d_y", i), y0, vecs[i].y);
            chk($sformatf("v%0d_dir", i), {dx0, dy0}, {vecs[i].dx, vecs[i].dy});
            chk($sformatf("v%0d_alive", i), alive0, vecs[i].alive);
            chk($sformatf("v%0d_cnt", i), cnt0, vecs[i].cnt);
            chk($sformatf("v%0d_play", i), play0, 1'b1);
        end

        // final kill: alive empties on the first edge, CLEAR follows on the next
        @(negedge Clk) hit0 = 8'hFF;
        @(negedge Clk) hit0 = 8'h00;
        chk("kill_alive", alive0, 8'h00);
        chk("kill_del_early", del0, 1'b0);
        @(negedge Clk);
        chk("clear_flags", {clr0, inv0, play0, del0}, 4'b1001);
        @(negedge Clk);
        chk("clear_del_off", {clr0, del0}, 2'b10);

        // new wave from CLEAR, then reset mid-wave
        @(negedge Clk) start0 = 1'b1;
        @(negedge Clk) start0 = 1'b0;
        chk("restart", {play0, alive0, x0}, {1'b1, 8'hFF, 10'd120});
        frames(4);
        chk("restart_step", x0, 10'd121);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1 chk("async_rst", {play0, alive0, x0, dx0}, {1'b0, 8'h00, 10'd120, 1'b1});
        del_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (del0) del_seen++;
        end
        chk("rst_no_delete", del_seen, 0);
        Reset = 1'b0;
        frames(8);
        chk("idle_after_rst", {play0, x0, clr0, inv0}, {1'b0, 10'd120, 1'b0, 1'b0});

        // floor reached without a final kill
        @(negedge Clk) start1 = 1'b1;
        @(negedge Clk) start1 = 1'b0;
        frames(1);
        chk("u1_drop", {dy1, dx1, x1}, {1'b1, 1'b0, 10'd239});
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        chk("u1_invaded", {inv1, clr1, play1, del1, y1}, {1'b1, 1'b0, 1'b0, 1'b1, 10'd41});
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        chk("u1_del_off", {inv1, del1}, 2'b10);

        // floor reached on the same step as the final kill: CLEAR must win
        @(negedge Clk) start1 = 1'b1;
        @(negedge Clk) start1 = 1'b0;
        hit1 = 8'h7F;
        @(negedge Clk) hit1 = 8'h00;
        frames(1);
        chk("u1b_drop", {dy1, alive1}, {1'b1, 8'h80});
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk) hit1 = 8'h80;
        @(negedge Clk) hit1 = 8'h00;
        chk("u1b_step", {y1, alive1}, {10'd41, 8'h00});
        @(negedge Clk);
        chk("u1b_clear_wins", {clr1, inv1, del1}, 3'b101);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        chk("u1b_hold", {clr1, inv1, play1}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
